// File: rtl/sopc_run_monitor.sv
// Reset sequencer and run monitor: stretches rst into cpu_rst_o, counts RUN cycles, ends on tohost store, halt or budget.
// Latency: status outputs are decoded from the state register and are valid one edge after the deciding input cycle.
// Backpressure: none; inputs are sampled only in RUN. Optional self-loop halt detect: SOPC_RUN_MONITOR_HALT_DETECT_EN.
module sopc_run_monitor #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                CNT_W        = 32,
    parameter int                RESET_CYCLES = 10,
    parameter int                MAX_CYCLES   = 50,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(32'h0000_1000),
    parameter logic [DATA_W-1:0] PASS_VALUE   = DATA_W'(1),
    parameter int                STALL_LIMIT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              cpu_rst_o,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [DATA_W-1:0] result_o,
    output logic              timeout_o,
    output logic              halted_o
);

    if (RESET_CYCLES < 1) begin : g_chk_reset
        $error("sopc_run_monitor: RESET_CYCLES must be >= 1");
    end
    if (MAX_CYCLES < 1 || (CNT_W < 63 && longint'(MAX_CYCLES) >= (longint'(1) << CNT_W))) begin : g_chk_max
        $error("sopc_run_monitor: MAX_CYCLES must be >= 1 and < 2**CNT_W");
    end
    if (STALL_LIMIT < 1) begin : g_chk_stall
        $error("sopc_run_monitor: STALL_LIMIT must be >= 1");
    end

    localparam int                HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT,
        ST_HALT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [CNT_W-1:0]    cycle_cnt;
    logic [DATA_W-1:0]   result_r;
    logic                pass_r;
    logic                store_hit;
    logic                budget_hit;
    logic                halt_hit;
    logic [DATA_W-1:0]   halt_pc;

    assign store_hit  = mem_we_i && (mem_addr_i == TOHOST_ADDR);
    assign budget_hit = (cycle_cnt == CNT_LAST);

`ifdef SOPC_RUN_MONITOR_HALT_DETECT_EN
    localparam int                 STALL_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    logic [ADDR_W-1:0]  pc_d1;
    logic [ADDR_W-1:0]  pc_d2;
    logic               pc_v1;
    logic               pc_v2;
    logic [STALL_W-1:0] stall_cnt;
    logic               pc_match;

    // Two-back compare catches "b ." with its delay slot (X, X+4, X, ...).
    assign pc_match = pc_v2 && (pc_i == pc_d2);
    assign halt_hit = pc_match && (stall_cnt == STALL_LAST);
    assign halt_pc  = DATA_W'(pc_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_d1     <= '0;
            pc_d2     <= '0;
            pc_v1     <= 1'b0;
            pc_v2     <= 1'b0;
            stall_cnt <= '0;
        end else if (state == ST_RUN) begin
            pc_d1     <= pc_i;
            pc_d2     <= pc_d1;
            pc_v1     <= 1'b1;
            pc_v2     <= pc_v1;
            stall_cnt <= pc_match ? stall_cnt + 1'b1 : '0;
        end else begin
            pc_v1     <= 1'b0;
            pc_v2     <= 1'b0;
            stall_cnt <= '0;
        end
    end
`else
    logic unused_pc;

    assign unused_pc = ^pc_i;
    assign halt_hit  = 1'b0;
    assign halt_pc   = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (store_hit)       state_nxt = ST_DONE;
                else if (halt_hit)   state_nxt = ST_HALT;
                else if (budget_hit) state_nxt = ST_TIMEOUT;
            end
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        cpu_rst_o = (state == ST_HOLD);
        done_o    = (state == ST_DONE);
        pass_o    = (state == ST_DONE) && pass_r;
        timeout_o = (state == ST_TIMEOUT);
        halted_o  = (state == ST_HALT);
    end

    // The run counter only advances while staying in RUN, so it freezes on the exit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            cycle_cnt <= '0;
            result_r  <= '0;
            pass_r    <= 1'b0;
        end else begin
            if (state == ST_HOLD && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (state == ST_RUN) begin
                if (state_nxt == ST_RUN) begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                end
                if (store_hit) begin
                    result_r <= mem_data_i;
                    pass_r   <= (mem_data_i == PASS_VALUE);
                end else if (halt_hit) begin
                    result_r <= halt_pc;
                end
            end
        end
    end

    assign cycle_cnt_o = cycle_cnt;
    assign result_o    = result_r;

endmodule

// File: doc/sopc_run_monitor.md
# sopc_run_monitor

Simulation-side reset sequencer and run monitor for the minimal SOPC. It stretches the raw bench reset into a CPU reset held for a fixed number of clocks and counts CPU run cycles. It ends the run on a store to a designated "tohost" address, which yields a pass or fail result, or on a cycle-budget timeout. Bench stop logic keys off its sticky status outputs instead of a hard-coded delay.

## Interface
Parameters:
- ADDR_W, 32, width of PC and data-memory address
- DATA_W, 32, width of store data
- CNT_W, 32, width of run-cycle counter
- RESET_CYCLES, 10, clocks `cpu_rst_o` stays high after `rst` drops (≥1)
- MAX_CYCLES, 50, run-cycle budget before timeout (≥1, < 2^CNT_W)
- TOHOST_ADDR, 32'h0000_1000, store address that ends the run
- PASS_VALUE, 1, store data meaning pass
- STALL_LIMIT, 8, consecutive loop matches that mean halted (≥1; used only with HALT_DETECT_EN)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_rst_o  out  1  reset to CPU/SOPC, active-high
- pc_i  in  ADDR_W  CPU fetch PC
- mem_we_i  in  1  data-memory write enable
- mem_addr_i  in  ADDR_W  data-memory write address
- mem_data_i  in  DATA_W  data-memory write data
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed
- done_o  out  1  run ended by tohost store (sticky)
- pass_o  out  1  tohost data == PASS_VALUE (valid when done_o)
- result_o  out  DATA_W  captured tohost data, or PC on halt
- timeout_o  out  1  budget exhausted (sticky)
- halted_o  out  1  self-loop halt detected (sticky)

## Operation
- FSM states: HOLD, RUN, DONE, TIMEOUT, HALT.
- Reset values: state = HOLD, hold counter = 0, `cpu_rst_o` = 1, `cycle_cnt_o` = 0, and `done_o`, `pass_o`, `timeout_o`, `halted_o` = 0, `result_o` = 0.
- HOLD: hold counter increments each clock. When it equals RESET_CYCLES-1, the FSM goes to RUN and `cpu_rst_o` goes to 0 on the same edge.
- RUN: `cycle_cnt_o` increments each clock.
  - Store hit: `mem_we_i` = 1 and `mem_addr_i` == TOHOST_ADDR. FSM goes to DONE, `result_o` ← `mem_data_i`, `pass_o` ← (`mem_data_i` == PASS_VALUE).
  - Budget exhausted: `cycle_cnt_o` == MAX_CYCLES-1. FSM goes to TIMEOUT.
  - Priority on the same edge: store hit > halt > timeout.
- DONE / TIMEOUT / HALT: terminal until `rst`.
  - `cycle_cnt_o` freezes.
  - `cpu_rst_o` stays 0; the CPU keeps running.
  - Stores to TOHOST_ADDR are ignored, and `result_o` does not change.
- Status outputs are registered, mutually exclusive, and decoded from state. `pass_o` is 0 unless in DONE.
- `rst` asserted in any state: all registers return to reset values immediately. This is asynchronous, with no clock needed.
- Counters never wrap. MAX_CYCLES < 2^CNT_W is a parameter-legality requirement and is checked by elaboration assertion, as is RESET_CYCLES ≥ 1.

## Timing
- `cpu_rst_o` falls on the RESET_CYCLES-th rising edge after `rst` deasserts.
- First RUN cycle: `cycle_cnt_o` = 0. It reads 1 after the next edge.
- Store hit sampled on edge N: `done_o`/`pass_o`/`result_o` are valid after edge N. This is one-cycle latency from the request cycle.
- Timeout: `timeout_o` rises on the edge where the count would reach MAX_CYCLES. `cycle_cnt_o` holds MAX_CYCLES-1.
- `mem_*` and `pc_i` are ignored outside RUN, including during HOLD, where the CPU is in reset.

## Configuration
- Macro: `SOPC_RUN_MONITOR_HALT_DETECT_EN`.
- Defined:
  - In RUN, compare `pc_i` with the PC registered two cycles earlier. This covers the `b .` idiom with its delay slot, where the PC alternates X, X+4.
  - Each match increments a stall counter; any mismatch clears it to 0.
  - When the counter reaches STALL_LIMIT, the FSM goes to HALT and `result_o` ← current `pc_i`.
  - The two-deep PC history invalidates on entry to RUN, so no match is possible in the first two RUN cycles.
- Not defined: no PC history or stall logic is built, HALT is unreachable, and `halted_o` is tied 0. `pc_i` stays in the port list, unused.

## Test plan
- RESET_CYCLES=10, `rst` high for 195 ns with a 20 ns clock, then low -> `cpu_rst_o` falls exactly 10 edges later; `cycle_cnt_o` = 0 on the first RUN cycle.
- In RUN cycle 20, store 32'h1 to 32'h1000 -> next cycle `done_o`=1, `pass_o`=1, `result_o`=1, and `cycle_cnt_o` frozen at 20.
- Store 32'hDEAD to 32'h1000 -> `done_o`=1, `pass_o`=0, `result_o`=32'hDEAD. A later store of 1 leaves outputs unchanged.
- MAX_CYCLES=50, no stores -> `timeout_o`=1 with `cycle_cnt_o`=49. A tohost store in that same final cycle gives `done_o`=1, `timeout_o`=0.
- With the macro, PC alternates 32'h40/32'h44 from run cycle 5 with STALL_LIMIT=8 -> `halted_o`=1, `result_o` = PC at the detect edge. Without the macro, the same stimulus times out.
- `rst` pulsed mid-RUN, asynchronous to clk -> all outputs return to reset values before the next edge, and `cpu_rst_o`=1 for another full hold.
